irq_controller: RTL and testbench
=================================

IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 The block SHALL have parameter VEC_BASE, default 10'h3F0, meaning the base program address of the 4-entry vector table.
REQ-002 The block SHALL have parameter TIMER_PERIOD, default 16'd1000, meaning the internal timer period in clk cycles (used only with IRQ_TIMER_EN).
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge of clk.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Ports i_except, i_syscall, i_timer and i_port, each input, 1 bit: interrupt request lines; an event is a 0->1 transition sampled on clk.
REQ-006 Port s_ack, input, 1 bit: the datapath has loaded dir_from_exception into the PC this cycle.
REQ-007 Port s_finished, input, 1 bit: the handler has executed its return.
REQ-008 Port s_we_mask, input, 1 bit: write enable for the mask register.
REQ-009 Port mask_in, input, 3 bits: enables for {port, timer, syscall}; 1 means enabled.
REQ-010 Port dir_from_exception, output, 10 bits: handler vector address for the PC mux.
REQ-011 Port s_interruption, output, 1 bit: interrupt request to the control unit.
REQ-012 Port irq_cause, output, 2 bits: cause of the active or requested interrupt.
REQ-013 Port irq_active, output, 1 bit: a handler is in service.

Function
REQ-014 Per source, the block SHALL keep a registered previous sample and a pending bit, and SHALL set the pending bit after edge k when the line is 1 at edge k and was 0 at edge k-1.
REQ-015 Cause encoding SHALL be: 0 = except, 1 = syscall, 2 = timer, 3 = port; priority SHALL be fixed with except highest and port lowest.
REQ-016 i_except SHALL be unmaskable; every other source SHALL be eligible only when its mask bit is 1; a masked source SHALL keep its pending bit.
REQ-017 The FSM SHALL have states IDLE, REQUEST and SERVICE.
REQ-018 In IDLE, if any pending source is eligible, the FSM SHALL go to REQUEST at the next edge and latch the highest-priority cause into irq_cause; otherwise it SHALL stay in IDLE.
REQ-019 Latency SHALL be exactly 2 edges: an event sampled at edge k gives s_interruption = 1 after edge k+1.
REQ-020 In REQUEST, s_interruption SHALL be 1 and dir_from_exception SHALL equal VEC_BASE + {irq_cause, 2'b00} (10-bit, wrap-around modulo 1024); the latched cause SHALL NOT change while in REQUEST.
REQ-021 In REQUEST with s_ack = 1, the FSM SHALL go to SERVICE and clear the served pending bit; if a new event on that same source arrives in the same cycle, the set SHALL win.
REQ-022 In SERVICE, irq_active SHALL be 1 and s_interruption SHALL be 0; there SHALL be no nesting, and new events SHALL only accumulate as pending.
REQ-023 In SERVICE with s_finished = 1, the FSM SHALL return to IDLE; remaining pending interrupts SHALL then be taken per REQ-018.
REQ-024 s_ack outside REQUEST and s_finished outside SERVICE SHALL be ignored.
REQ-025 s_we_mask = 1 SHALL load mask_in at the next edge in any state; the new mask SHALL affect eligibility only from the following IDLE evaluation.
REQ-026 dir_from_exception SHALL be 10'd0 whenever the state is not REQUEST.

Reset
REQ-027 When reset = 1 at an edge, the block SHALL go to IDLE, clear all pending bits and previous samples, set the mask to 3'b111 and the timer counter to 0, and drive s_interruption = 0, irq_active = 0, irq_cause = 0 and dir_from_exception = 0; this SHALL apply mid-REQUEST and mid-SERVICE, with no interrupt lost silently beyond those pending bits.

Configuration
REQ-028 With IRQ_TIMER_EN defined, an internal counter SHALL count 0..TIMER_PERIOD-1 and wrap, producing a one-cycle tick at the wrap; the tick SHALL be ORed with the i_timer edge event.
REQ-029 Without IRQ_TIMER_EN, no counter SHALL exist, and the timer source SHALL be i_timer edges only.

Structure
REQ-030 Package irq_pkg SHALL hold the state enum, the cause encodings, the 2-bit cause type and the vector stride constant (4).
REQ-031 One sub-module, irq_pending_bit (edge detect plus pending set/clear with set priority), SHALL be instantiated once per source.

Verification
REQ-032 The bench SHALL cover: i_timer 0->1 at edge 10 -> s_interruption = 1 after edge 11, irq_cause = 2, dir_from_exception = 10'h3F8.
REQ-033 The bench SHALL cover: i_port and i_except rising at the same edge -> except served first (10'h3F0); after s_ack then s_finished, port is served (10'h3FC).
REQ-034 The bench SHALL cover: mask_in = 3'b000 then i_syscall pulse -> no request; writing mask 3'b001 -> request with cause 1 and vector 10'h3F4.
REQ-035 The bench SHALL cover: i_timer event during SERVICE -> no s_interruption until s_finished, then timer request 2 edges later.
REQ-036 The bench SHALL cover: reset asserted in SERVICE with pending port -> all outputs 0 and no request after reset deasserts.
REQ-037 The bench SHALL cover, with IRQ_TIMER_EN defined and TIMER_PERIOD = 5: timer requests every 5 cycles while each is acked and finished within 2 cycles.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package irq_pkg;

  // Controller FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  // 2-bit interrupt cause; value also indexes the vector table
  typedef logic [1:0] irq_cause_t;

  localparam irq_cause_t CAUSE_EXCEPT  = 2'd0;
  localparam irq_cause_t CAUSE_SYSCALL = 2'd1;
  localparam irq_cause_t CAUSE_TIMER   = 2'd2;
  localparam irq_cause_t CAUSE_PORT    = 2'd3;

  // Distance in program words between consecutive vector entries
  localparam int VEC_STRIDE = 4;

  // Fixed priority: lowest index (except) wins
  function automatic irq_cause_t pick_cause(input logic [3:0] elig);
    irq_cause_t c;
    c = CAUSE_PORT;
    if (elig[2]) c = CAUSE_TIMER;
    if (elig[1]) c = CAUSE_SYSCALL;
    if (elig[0]) c = CAUSE_EXCEPT;
    return c;
  endfunction

  // Vector entry address, wrapping modulo 1024
  function automatic logic [9:0] vec_addr(input logic [9:0] base, input irq_cause_t c);
    return base + (10'(c) * 10'(VEC_STRIDE));
  endfunction

endpackage

// File: rtl/irq_pending_bit.sv
// Edge detector plus sticky pending flag for one interrupt source.
// Latency: line rising at edge k sets pending after edge k.
// Backpressure: none; a set in the same cycle as a clear wins.
module irq_pending_bit (
  input  logic clk,
  input  logic reset,
  input  logic line,
  input  logic extra_evt,
  input  logic clr,
  output logic pending
);

  logic prev;
  logic evt;

  assign evt = (line & ~prev) | extra_evt;

  // Track previous sample; set has priority over clear
  always_ff @(posedge clk) begin
    if (reset) begin
      prev    <= 1'b0;
      pending <= 1'b0;
    end else begin
      prev <= line;
      if (evt)      pending <= 1'b1;
      else if (clr) pending <= 1'b0;
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Four-source prioritised interrupt controller with vector output (optional internal timer: IRQ_TIMER_EN).
// Latency: request line edge at edge k -> s_interruption high after edge k+1.
// Backpressure: request held until s_ack; no nesting, new events stay pending until s_finished.
module irq_controller
  import irq_pkg::*;
#(
  parameter logic [9:0]  VEC_BASE     = 10'h3F0,
  parameter logic [15:0] TIMER_PERIOD = 16'd1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_except,
  input  logic       i_syscall,
  input  logic       i_timer,
  input  logic       i_port,
  input  logic       s_ack,
  input  logic       s_finished,
  input  logic       s_we_mask,
  input  logic [2:0] mask_in,
  output logic [9:0] dir_from_exception,
  output logic       s_interruption,
  output logic [1:0] irq_cause,
  output logic       irq_active
);

  irq_state_t state_q, state_d;
  irq_cause_t cause_q, cause_d;
  logic [2:0] mask_q;
  logic [3:0] lines;
  logic [3:0] extra_evt;
  logic [3:0] clr;
  logic [3:0] pending;
  logic [3:0] eligible;
  logic       timer_tick;

`ifdef IRQ_TIMER_EN
  logic [15:0] tmr_cnt;

  assign timer_tick = (tmr_cnt == (TIMER_PERIOD - 16'd1));

  // Free-running period counter; tick on the wrap cycle
  always_ff @(posedge clk) begin
    if (reset)           tmr_cnt <= 16'd0;
    else if (timer_tick) tmr_cnt <= 16'd0;
    else                 tmr_cnt <= tmr_cnt + 16'd1;
  end
`else
  logic unused_timer_period;
  assign unused_timer_period = ^TIMER_PERIOD;
  assign timer_tick = 1'b0;
`endif

  // Index order matches cause encoding: except, syscall, timer, port
  assign lines     = {i_port, i_timer, i_syscall, i_except};
  assign extra_evt = {1'b0, timer_tick, 2'b00};
  // Except is always eligible; mask covers {port, timer, syscall}
  assign eligible  = pending & {mask_q, 1'b1};

  for (genvar i = 0; i < 4; i++) begin : g_src
    irq_pending_bit u_bit (
      .clk       (clk),
      .reset     (reset),
      .line      (lines[i]),
      .extra_evt (extra_evt[i]),
      .clr       (clr[i]),
      .pending   (pending[i])
    );
  end

  // Clear only the source being acknowledged
  always_comb begin
    clr = 4'b0000;
    if (state_q == REQUEST && s_ack) clr[cause_q] = 1'b1;
  end

  // Next-state and cause latch decisions
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d = REQUEST;
          cause_d = pick_cause(eligible);
        end
      end
      REQUEST: if (s_ack)      state_d = SERVICE;
      SERVICE: if (s_finished) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, cause and mask registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cause_q <= CAUSE_EXCEPT;
      mask_q  <= 3'b111;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (s_we_mask) mask_q <= mask_in;
    end
  end

  assign s_interruption     = (state_q == REQUEST);
  assign irq_active         = (state_q == SERVICE);
  assign irq_cause          = cause_q;
  assign dir_from_exception = (state_q == REQUEST) ? vec_addr(VEC_BASE, cause_q) : 10'd0;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller (timer-tick scenario when IRQ_TIMER_EN is defined).
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: s_ack / s_finished driven by the bench as the datapath.
module tb_irq_controller;

`ifdef IRQ_TIMER_EN
  localparam logic [15:0] TP = 16'd5;
`else
  localparam logic [15:0] TP = 16'd1000;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       i_except, i_syscall, i_timer, i_port;
  logic       s_ack, s_finished, s_we_mask;
  logic [2:0] mask_in;
  logic [9:0] dir_from_exception;
  logic       s_interruption;
  logic [1:0] irq_cause;
  logic       irq_active;

  int n_cmp = 0;
  int n_bad = 0;

  irq_controller #(.VEC_BASE(10'h3F0), .TIMER_PERIOD(TP)) dut (
    .clk                (clk),
    .reset              (reset),
    .i_except           (i_except),
    .i_syscall          (i_syscall),
    .i_timer            (i_timer),
    .i_port             (i_port),
    .s_ack              (s_ack),
    .s_finished         (s_finished),
    .s_we_mask          (s_we_mask),
    .mask_in            (mask_in),
    .dir_from_exception (dir_from_exception),
    .s_interruption     (s_interruption),
    .irq_cause          (irq_cause),
    .irq_active         (irq_active)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_sint"}, 32'(s_interruption), 32'd0);
    check({tag, "_act"},  32'(irq_active), 32'd0);
    check({tag, "_cause"}, 32'(irq_cause), 32'd0);
    check({tag, "_dir"},  32'(dir_from_exception), 32'd0);
  endtask

  initial begin
    reset = 1'b1; i_except = 0; i_syscall = 0; i_timer = 0; i_port = 0;
    s_ack = 0; s_finished = 0; s_we_mask = 0; mask_in = 3'b111;
    tick();
    tick();
    check_idle_outputs("reset");
    reset = 1'b0;

`ifdef IRQ_TIMER_EN
    // Counter restarts at reset: tick sets pending at edge 5, request after edge 6, every 5 edges
    for (int n = 1; n <= 26; n++) begin
      tick();
      s_ack = 1'b0;
      s_finished = 1'b0;
      if (n >= 6 && ((n - 6) % 5) == 0) begin
        check("tmr_req", 32'(s_interruption), 32'd1);
        check("tmr_cause", 32'(irq_cause), 32'd2);
        check("tmr_dir", 32'(dir_from_exception), 32'h3F8);
        s_ack = 1'b1;
      end else if (n >= 6 && ((n - 6) % 5) == 1) begin
        check("tmr_svc", 32'(irq_active), 32'd1);
        check("tmr_svc_sint", 32'(s_interruption), 32'd0);
        s_finished = 1'b1;
      end else begin
        check("tmr_quiet", 32'(s_interruption), 32'd0);
        check("tmr_quiet_act", 32'(irq_active), 32'd0);
      end
    end
`else
    // Stray ack/finished in IDLE are ignored
    s_ack = 1'b1; s_finished = 1'b1;
    tick();
    s_ack = 1'b0; s_finished = 1'b0;
    check("stray_idle", 32'(s_interruption), 32'd0);

    // Timer edge: pending after first edge, request after second
    i_timer = 1'b1;
    tick();
    check("tmr_lat1", 32'(s_interruption), 32'd0);
    tick();
    check("tmr_req", 32'(s_interruption), 32'd1);
    check("tmr_cause", 32'(irq_cause), 32'd2);
    check("tmr_dir", 32'(dir_from_exception), 32'h3F8);
    check("tmr_act0", 32'(irq_active), 32'd0);
    s_finished = 1'b1;          // ignored outside SERVICE
    tick();
    s_finished = 1'b0;
    check("req_hold", 32'(s_interruption), 32'd1);
    check("req_hold_cause", 32'(irq_cause), 32'd2);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    check("svc_act", 32'(irq_active), 32'd1);
    check("svc_sint", 32'(s_interruption), 32'd0);
    check("svc_dir", 32'(dir_from_exception), 32'd0);
    s_finished = 1'b1;
    tick();
    s_finished = 1'b0;
    check("fin_act", 32'(irq_active), 32'd0);
    tick();
    check("tmr_cleared", 32'(s_interruption), 32'd0);
    i_timer = 1'b0;

    // Simultaneous port + except: except first, then port
    i_port = 1'b1; i_except = 1'b1;
    tick();
    tick();
    check("exc_cause", 32'(irq_cause), 32'd0);
    check("exc_dir", 32'(dir_from_exception), 32'h3F0);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0; s_finished = 1'b1;
    tick();
    s_finished = 1'b0;
    check("exc_done", 32'(s_interruption), 32'd0);
    tick();
    check("port_req", 32'(s_interruption), 32'd1);
    check("port_cause", 32'(irq_cause), 32'd3);
    check("port_dir", 32'(dir_from_exception), 32'h3FC);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0; s_finished = 1'b1;
    tick();
    s_finished = 1'b0; i_port = 1'b0; i_except = 1'b0;
    tick();
    check("all_served", 32'(s_interruption), 32'd0);

    // Masked syscall stays pending until unmasked
    s_we_mask = 1'b1; mask_in = 3'b000;
    tick();
    s_we_mask = 1'b0;
    i_syscall = 1'b1;
    tick();
    i_syscall = 1'b0;
    tick();
    check("mask_block1", 32'(s_interruption), 32'd0);
    tick();
    check("mask_block2", 32'(s_interruption), 32'd0);
    s_we_mask = 1'b1; mask_in = 3'b001;
    tick();
    s_we_mask = 1'b0;
    check("mask_wr_edge", 32'(s_interruption), 32'd0);
    tick();
    check("sys_req", 32'(s_interruption), 32'd1);
    check("sys_cause", 32'(irq_cause), 32'd1);
    check("sys_dir", 32'(dir_from_exception), 32'h3F4);
    s_ack = 1'b1; s_we_mask = 1'b1; mask_in = 3'b111;
    tick();
    s_ack = 1'b0; s_we_mask = 1'b0; s_finished = 1'b1;
    tick();
    s_finished = 1'b0;

    // Timer event during SERVICE waits for s_finished
    i_port = 1'b1;
    tick();
    tick();
    check("p2_cause", 32'(irq_cause), 32'd3);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0; i_port = 1'b0; i_timer = 1'b1;
    tick();
    tick();
    check("nest_sint1", 32'(s_interruption), 32'd0);
    check("nest_act", 32'(irq_active), 32'd1);
    tick();
    check("nest_sint2", 32'(s_interruption), 32'd0);
    s_finished = 1'b1;
    tick();
    s_finished = 1'b0;
    check("post_fin_idle", 32'(s_interruption), 32'd0);
    tick();
    check("late_tmr_req", 32'(s_interruption), 32'd1);
    check("late_tmr_cause", 32'(irq_cause), 32'd2);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0; i_timer = 1'b0;

    // Reset in SERVICE with port pending discards everything
    i_port = 1'b1;
    tick();
    i_port = 1'b0;
    check("rst_pre_act", 32'(irq_active), 32'd1);
    reset = 1'b1;
    tick();
    check_idle_outputs("rst_svc");
    reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      check("rst_quiet", 32'(s_interruption), 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
